// File: rtl/rabbit_sched_if.sv
// Host/datapath handshake bundle for the Rabbit sequencing controller.
// The master side drives requests and datapath status; the slave side is
// the scheduler, which returns strobes, status and counters.
interface rabbit_sched_if #(
    parameter int BLK_W = 32
) ();
    logic             start;
    logic             iv_en;
    logic             stop;
    logic             step_done;
    logic             ks_ready;
    logic             key_load;
    logic             iv_load;
    logic             ctr_reinit;
    logic             step;
    logic             ks_valid;
    logic             busy;
    logic             setup_done;
    logic [3:0]       iter_cnt;
    logic [BLK_W-1:0] blk_cnt;
    logic             proto_err;

    modport master (
        output start, iv_en, stop, step_done, ks_ready,
        input  key_load, iv_load, ctr_reinit, step, ks_valid,
        input  busy, setup_done, iter_cnt, blk_cnt, proto_err
    );

    modport slave (
        input  start, iv_en, stop, step_done, ks_ready,
        output key_load, iv_load, ctr_reinit, step, ks_valid,
        output busy, setup_done, iter_cnt, blk_cnt, proto_err
    );
endinterface

// File: rtl/rabbit_sched.sv
// Rabbit cipher sequencing controller: key load, key iterations, counter
// re-init, optional IV load and iterations, then keystream generation
// under a valid/ready handshake. Holds only sequencing state and counters.
module rabbit_sched #(
    parameter int KEY_ITERS = 4,
    parameter int IV_ITERS  = 4,
    parameter int BLK_W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    rabbit_sched_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE,
        KEY_LOAD,
        KEY_STEP,
        KEY_WAIT,
        REINIT,
        IV_LOAD,
        IV_STEP,
        IV_WAIT,
        GEN_STEP,
        GEN_WAIT,
        GEN_HOLD
    } state_t;

    localparam logic [3:0] KEY_LAST = 4'(KEY_ITERS - 1);
    localparam logic [3:0] IV_LAST  = 4'(IV_ITERS - 1);

    state_t           state_reg, state_next;
    logic [3:0]       iter_cnt_reg, iter_cnt_next;
    logic [BLK_W-1:0] blk_cnt_reg, blk_cnt_next;
    logic             stop_reg, stop_next;
    logic             iv_en_reg, iv_en_next;
    logic             proto_err_reg, proto_err_next;
    logic             in_wait;

    assign in_wait = (state_reg == KEY_WAIT) || (state_reg == IV_WAIT) ||
                     (state_reg == GEN_WAIT);

    // Next-state, counter and latch logic; strobes are decoded from state below.
    always_comb begin
        state_next     = state_reg;
        iter_cnt_next  = iter_cnt_reg;
        blk_cnt_next   = blk_cnt_reg;
        stop_next      = stop_reg;
        iv_en_next     = iv_en_reg;
        proto_err_next = proto_err_reg;

        // A stop request is remembered until the next block boundary; in
        // IDLE there is nothing to stop, so it is dropped.
        if (bus.stop && (state_reg != IDLE)) begin
            stop_next = 1'b1;
        end
        // step_done with no iteration outstanding is a datapath protocol fault.
        if (bus.step_done && !in_wait) begin
            proto_err_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    iv_en_next    = bus.iv_en;
                    iter_cnt_next = 4'd0;
                    blk_cnt_next  = '0;
                    state_next    = KEY_LOAD;
                end
            end
            KEY_LOAD: state_next = KEY_STEP;
            KEY_STEP: state_next = KEY_WAIT;
            KEY_WAIT: begin
                if (bus.step_done) begin
                    if (iter_cnt_reg == KEY_LAST) begin
                        iter_cnt_next = 4'd0;
                        state_next    = REINIT;
                    end else begin
                        iter_cnt_next = iter_cnt_reg + 4'd1;
                        state_next    = KEY_STEP;
                    end
                end
            end
            REINIT:   state_next = iv_en_reg ? IV_LOAD : GEN_STEP;
            IV_LOAD:  state_next = IV_STEP;
            IV_STEP:  state_next = IV_WAIT;
            IV_WAIT: begin
                if (bus.step_done) begin
                    if (iter_cnt_reg == IV_LAST) begin
                        iter_cnt_next = 4'd0;
                        state_next    = GEN_STEP;
                    end else begin
                        iter_cnt_next = iter_cnt_reg + 4'd1;
                        state_next    = IV_STEP;
                    end
                end
            end
            GEN_STEP: state_next = GEN_WAIT;
            GEN_WAIT: begin
                if (bus.step_done) begin
                    state_next = GEN_HOLD;
                end
            end
            GEN_HOLD: begin
                if (bus.ks_ready) begin
                    blk_cnt_next = blk_cnt_reg + BLK_W'(1);
                    if (stop_reg || bus.stop) begin
                        stop_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        state_next = GEN_STEP;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and counter registers; reset abandons any in-flight step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            iter_cnt_reg  <= 4'd0;
            blk_cnt_reg   <= '0;
            stop_reg      <= 1'b0;
            iv_en_reg     <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            iter_cnt_reg  <= iter_cnt_next;
            blk_cnt_reg   <= blk_cnt_next;
            stop_reg      <= stop_next;
            iv_en_reg     <= iv_en_next;
            proto_err_reg <= proto_err_next;
        end
    end

    assign bus.key_load   = (state_reg == KEY_LOAD);
    assign bus.iv_load    = (state_reg == IV_LOAD);
    assign bus.ctr_reinit = (state_reg == REINIT);
    assign bus.step       = (state_reg == KEY_STEP) || (state_reg == IV_STEP) ||
                            (state_reg == GEN_STEP);
    assign bus.ks_valid   = (state_reg == GEN_HOLD);
    assign bus.busy       = (state_reg != IDLE);
    assign bus.setup_done = (state_reg == GEN_STEP) || (state_reg == GEN_WAIT) ||
                            (state_reg == GEN_HOLD);
    assign bus.iter_cnt   = iter_cnt_reg;
    assign bus.blk_cnt    = blk_cnt_reg;
    assign bus.proto_err  = proto_err_reg;
endmodule

// File: tb/tb_rabbit_sched.sv
// Table-driven bench for rabbit_sched: each record gives one cycle of inputs
// and the controller phase/counters expected right after that clock edge.
module tb_rabbit_sched;
    localparam int KEY_ITERS = 4;
    localparam int IV_ITERS  = 4;
    localparam int BLK_W     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rabbit_sched_if #(.BLK_W(BLK_W)) bus ();

    rabbit_sched #(
        .KEY_ITERS(KEY_ITERS),
        .IV_ITERS (IV_ITERS),
        .BLK_W    (BLK_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef enum int {S_IDLE, S_KL, S_KS, S_KW, S_RI, S_IL, S_IS, S_IW, S_GS, S_GW, S_GH} ph_t;

    typedef struct packed {
        logic             key_load;
        logic             iv_load;
        logic             ctr_reinit;
        logic             step;
        logic             ks_valid;
        logic             busy;
        logic             setup_done;
        logic [3:0]       iter_cnt;
        logic [BLK_W-1:0] blk_cnt;
        logic             proto_err;
    } out_t;

    typedef struct {
        bit  rst;
        bit  start;
        bit  iv_en;
        bit  stop;
        bit  step_done;
        bit  ks_ready;
        ph_t ph;
        int  iter;
        int  blk;
        bit  perr;
        bit  mark_base;
        int  chk_steps;
    } vec_t;

    vec_t  vecs[$];
    string names[$];
    int    tests = 0;
    int    fails = 0;
    int    step_total = 0;
    int    step_base = 0;

    // Count step strobes once per cycle, away from the active edge.
    always @(negedge clk) if (bus.step === 1'b1) step_total++;

    // Moore outputs expected in each controller phase.
    function automatic out_t exp_out(ph_t ph, int iter, int blk, bit perr);
        out_t o;
        o            = '0;
        o.key_load   = (ph == S_KL);
        o.iv_load    = (ph == S_IL);
        o.ctr_reinit = (ph == S_RI);
        o.step       = (ph == S_KS) || (ph == S_IS) || (ph == S_GS);
        o.ks_valid   = (ph == S_GH);
        o.busy       = (ph != S_IDLE);
        o.setup_done = (ph == S_GS) || (ph == S_GW) || (ph == S_GH);
        o.iter_cnt   = 4'(iter);
        o.blk_cnt    = BLK_W'(blk);
        o.proto_err  = perr;
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.key_load   = bus.key_load;
        o.iv_load    = bus.iv_load;
        o.ctr_reinit = bus.ctr_reinit;
        o.step       = bus.step;
        o.ks_valid   = bus.ks_valid;
        o.busy       = bus.busy;
        o.setup_done = bus.setup_done;
        o.iter_cnt   = bus.iter_cnt;
        o.blk_cnt    = bus.blk_cnt;
        o.proto_err  = bus.proto_err;
        return o;
    endfunction

    function automatic void add(bit r, bit st, bit iv, bit sp, bit sd, bit rd,
                                ph_t ph, int iter, int blk, bit perr, string nm,
                                bit mb = 1'b0, int cs = -1);
        vec_t v;
        v.rst = r; v.start = st; v.iv_en = iv; v.stop = sp;
        v.step_done = sd; v.ks_ready = rd;
        v.ph = ph; v.iter = iter; v.blk = blk; v.perr = perr;
        v.mark_base = mb; v.chk_steps = cs;
        vecs.push_back(v);
        names.push_back(nm);
    endfunction

    // Step/wait pairs of one setup phase, step_done returned in each wait.
    function automatic void add_iters(bit iv, ph_t exit_ph, int blk, bit perr);
        int  n;
        ph_t sp;
        ph_t wp;
        n  = iv ? IV_ITERS : KEY_ITERS;
        sp = iv ? S_IS : S_KS;
        wp = iv ? S_IW : S_KW;
        for (int i = 0; i < n; i++) begin
            add(0, 0, 0, 0, 0, 0, wp, i, blk, perr, "iter_wait");
            if (i < n - 1) add(0, 0, 0, 0, 1, 0, sp, i + 1, blk, perr, "iter_next");
            else           add(0, 0, 0, 0, 1, 0, exit_ph, 0, blk, perr, "iter_exit");
        end
    endfunction

    task automatic check(string nm, out_t got, out_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got=%h exp=%h", nm, got, exp);
        end else begin
            $display("[TB] ok   %s out=%h", nm, got);
        end
    endtask

    initial begin
        bit seen;
        bit was_step;

        rst = 1'b1;
        bus.start = 1'b0; bus.iv_en = 1'b0; bus.stop = 1'b0;
        bus.step_done = 1'b0; bus.ks_ready = 1'b0;

        // reset
        add(1, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, "reset0");
        add(1, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, "reset1");
        // setup without IV: key_load c1, steps c2/4/6/8, reinit c10, step c11, valid c13
        add(0, 1, 0, 0, 0, 0, S_KL, 0, 0, 0, "start_noiv", 1);
        add(0, 0, 0, 0, 0, 0, S_KS, 0, 0, 0, "first_step");
        add_iters(0, S_RI, 0, 0);
        add(0, 0, 0, 0, 0, 0, S_GS, 0, 0, 0, "reinit_to_gen");
        add(0, 0, 0, 0, 0, 0, S_GW, 0, 0, 0, "gen_wait");
        add(0, 0, 0, 0, 1, 0, S_GH, 0, 0, 0, "first_valid", 0, KEY_ITERS + 1);
        // backpressure, with a start that must be ignored
        for (int i = 0; i < 5; i++)
            add(0, i == 1, 1, 0, 0, 0, S_GH, 0, 0, 0, "bp_hold");
        add(0, 0, 0, 0, 0, 1, S_GS, 0, 1, 0, "bp_accept");
        add(0, 0, 0, 0, 0, 0, S_GW, 0, 1, 0, "gen_wait2");
        add(0, 0, 0, 1, 1, 0, S_GH, 0, 1, 0, "stop_latched");
        add(0, 0, 0, 0, 0, 1, S_IDLE, 0, 2, 0, "stop_return");
        add(0, 0, 0, 1, 0, 1, S_IDLE, 0, 2, 0, "idle_stop_ready");
        // setup with IV
        add(0, 1, 1, 0, 0, 0, S_KL, 0, 0, 0, "start_iv", 1);
        add(0, 0, 0, 0, 0, 0, S_KS, 0, 0, 0, "iv_key_step");
        add_iters(0, S_RI, 0, 0);
        add(0, 0, 0, 0, 0, 0, S_IL, 0, 0, 0, "reinit_to_iv");
        add(0, 0, 0, 0, 0, 0, S_IS, 0, 0, 0, "iv_step");
        add_iters(1, S_GS, 0, 0);
        add(0, 0, 0, 0, 0, 0, S_GW, 0, 0, 0, "iv_gen_wait");
        add(0, 0, 0, 0, 1, 0, S_GH, 0, 0, 0, "iv_first_valid", 0, KEY_ITERS + IV_ITERS + 1);
        // 15 blocks, then stop with ready on block 16 wraps the counter
        for (int b = 0; b < 15; b++) begin
            add(0, 0, 0, 0, 0, 1, S_GS, 0, b + 1, 0, "blk_accept");
            add(0, 0, 0, 0, 0, 0, S_GW, 0, b + 1, 0, "blk_wait");
            add(0, 0, 0, 0, 1, 0, S_GH, 0, b + 1, 0, "blk_valid");
        end
        add(0, 0, 0, 1, 0, 1, S_IDLE, 0, 0, 0, "wrap_stop");
        // protocol error and ignored start
        add(0, 0, 0, 0, 1, 0, S_IDLE, 0, 0, 1, "proto_idle");
        add(0, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 1, "proto_sticky");
        add(0, 1, 1, 0, 0, 0, S_KL, 0, 0, 1, "start_iv2");
        add(0, 0, 0, 0, 0, 0, S_KS, 0, 0, 1, "k_step0");
        add(0, 0, 0, 0, 0, 0, S_KW, 0, 0, 1, "k_wait0");
        add(0, 0, 0, 0, 1, 0, S_KS, 1, 0, 1, "k_step1");
        add(0, 0, 0, 0, 0, 0, S_KW, 1, 0, 1, "k_wait1");
        add(0, 1, 0, 0, 0, 0, S_KW, 1, 0, 1, "start_ignored");
        add(0, 0, 0, 0, 1, 0, S_KS, 2, 0, 1, "k_step2");
        add(0, 0, 0, 0, 0, 0, S_KW, 2, 0, 1, "k_wait2");
        add(0, 0, 0, 0, 1, 0, S_KS, 3, 0, 1, "k_step3");
        add(0, 0, 0, 0, 0, 0, S_KW, 3, 0, 1, "k_wait3");
        add(0, 0, 0, 0, 1, 0, S_RI, 0, 0, 1, "k_exit");
        add(0, 0, 0, 0, 0, 0, S_IL, 0, 0, 1, "iv_not_resampled");
        add(0, 0, 0, 0, 0, 0, S_IS, 0, 0, 1, "i_step0");
        add(0, 0, 0, 0, 0, 0, S_IW, 0, 0, 1, "i_wait0");
        add(0, 0, 0, 0, 1, 0, S_IS, 1, 0, 1, "i_step1");
        add(0, 0, 0, 0, 0, 0, S_IW, 1, 0, 1, "i_wait1");
        add(0, 0, 0, 0, 1, 0, S_IS, 2, 0, 1, "i_step2");
        add(0, 0, 0, 0, 0, 0, S_IW, 2, 0, 1, "iv_wait_iter2");
        // reset mid-operation, then full replay
        add(1, 0, 0, 0, 1, 0, S_IDLE, 0, 0, 0, "reset_mid");
        add(0, 1, 0, 0, 0, 0, S_KL, 0, 0, 0, "replay_key_load", 1);
        add(0, 0, 0, 0, 0, 0, S_KS, 0, 0, 0, "replay_step");
        add_iters(0, S_RI, 0, 0);
        add(0, 0, 0, 0, 0, 0, S_GS, 0, 0, 0, "replay_gen");
        add(0, 0, 0, 0, 0, 0, S_GW, 0, 0, 0, "replay_wait");
        add(0, 0, 0, 0, 1, 0, S_GH, 0, 0, 0, "replay_valid", 0, KEY_ITERS + 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.start     = vecs[i].start;
            bus.iv_en     = vecs[i].iv_en;
            bus.stop      = vecs[i].stop;
            bus.step_done = vecs[i].step_done;
            bus.ks_ready  = vecs[i].ks_ready;
            @(posedge clk);
            #1;
            check(names[i], dut_out(),
                  exp_out(vecs[i].ph, vecs[i].iter, vecs[i].blk, vecs[i].perr));
            if (vecs[i].mark_base) step_base = step_total;
            if (vecs[i].chk_steps >= 0) begin
                tests++;
                if (step_total - step_base != vecs[i].chk_steps) begin
                    fails++;
                    $display("[TB] FAIL step_count(%s) got=%0d exp=%0d",
                             names[i], step_total - step_base, vecs[i].chk_steps);
                end else begin
                    $display("[TB] ok   step_count(%s) %0d", names[i], step_total - step_base);
                end
            end
        end

        // Stop pulsed during setup: setup finishes, one block, then IDLE.
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
        bus.step_done = 1'b0; bus.ks_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b1; bus.iv_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        was_step = bus.step;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            bus.step_done = was_step;
            was_step = bus.step;
            if (bus.ks_valid === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL stop_setup_valid got=timeout exp=ks_valid");
        end else begin
            $display("[TB] ok   stop_setup_valid");
        end
        bus.step_done = 1'b0;
        bus.ks_ready  = 1'b1;
        @(posedge clk);
        #1;
        check("stop_setup_return", dut_out(), exp_out(S_IDLE, 0, 1, 0));
        @(negedge clk);
        bus.ks_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
